// File: rtl/vga_timing_gen.sv
// VGA timing generator: advances one pixel per board_clk cycle with my_clk high.
// Outputs are registered from next-state counters; run/stop takes effect only at frame wrap.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 10
) (
    input  logic          board_clk,
    input  logic          rst,
    input  logic          my_clk,
    input  logic          run,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] currentX,
    output logic [CW-1:0] currentY,
    output logic          line_start,
    output logic          frame_start,
    output logic          busy
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Thresholds are one bit wider so a window ending exactly at 2^CW still fits.
    localparam logic [CW:0] H_LAST = (CW+1)'(H_TOTAL - 1);
    localparam logic [CW:0] V_LAST = (CW+1)'(V_TOTAL - 1);
    localparam logic [CW:0] H_ACT  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] V_ACT  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] h, v, h_n, v_n;
    logic          h_last, v_last;

    logic          hs_d, vs_d, de_d, ls_d, fs_d, busy_d;
    logic [CW-1:0] x_d, y_d;

    assign h_last = ({1'b0, h} == H_LAST);
    assign v_last = ({1'b0, v} == V_LAST);

    always_ff @(posedge board_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            h     <= '0;
            v     <= '0;
        end else begin
            state <= state_n;
            h     <= h_n;
            v     <= v_n;
        end
    end

    always_comb begin
        state_n = state;
        h_n     = h;
        v_n     = v;
        if (my_clk) begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state_n = RUN;
                        h_n     = '0;
                        v_n     = '0;
                    end
                end
                default: begin
                    if (h_last && v_last) begin
                        h_n     = '0;
                        v_n     = '0;
                        state_n = run ? RUN : IDLE;
                    end else begin
                        if (h_last) begin
                            h_n = '0;
                            v_n = v + CW'(1);
                        end else begin
                            h_n = h + CW'(1);
                        end
                        state_n = run ? RUN : DRAIN;
                    end
                end
            endcase
        end
    end

    // In IDLE the counters are forced to 0, so coordinates fall out as 0 too.
    always_comb begin
        busy_d = (state_n != IDLE);
        hs_d   = (busy_d && {1'b0, h_n} >= HS_BEG && {1'b0, h_n} < HS_END) ? H_POL : ~H_POL;
        vs_d   = (busy_d && {1'b0, v_n} >= VS_BEG && {1'b0, v_n} < VS_END) ? V_POL : ~V_POL;
        de_d   = busy_d && ({1'b0, h_n} < H_ACT) && ({1'b0, v_n} < V_ACT);
        x_d    = ({1'b0, h_n} < H_ACT) ? h_n : CW'(H_ACTIVE - 1);
        y_d    = ({1'b0, v_n} < V_ACT) ? v_n : CW'(V_ACTIVE - 1);
        ls_d   = my_clk && busy_d && (h_n == '0);
        fs_d   = ls_d && (v_n == '0);
    end

    always_ff @(posedge board_clk or posedge rst) begin
        if (rst) begin
            hs          <= ~H_POL;
            vs          <= ~V_POL;
            de          <= 1'b0;
            currentX    <= '0;
            currentY    <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            hs          <= hs_d;
            vs          <= vs_d;
            de          <= de_d;
            currentX    <= x_d;
            currentY    <= y_d;
            line_start  <= ls_d;
            frame_start <= fs_d;
            busy        <= busy_d;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with small timing; a position-counter model predicts every output.
module tb_vga_timing_gen;
    localparam int HA = 8, HFP = 2, HSY = 3, HBP = 2, HT = HA + HFP + HSY + HBP;
    localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1, VT = VA + VFP + VSY + VBP;
    localparam int NPIX = HT * VT;
    localparam logic [13:0] POL_FLIP = 14'h3000;

    logic board_clk = 1'b0;
    logic rst = 1'b1, my_clk = 1'b0, run = 1'b0;
    logic hs, vs, de, ls, fs, busy;
    logic hs2, vs2, de2, ls2, fs2, busy2;
    logic [3:0] cx, cy, cx2, cy2;
    logic [13:0] act1, act2;

    int n_checks = 0, n_pass = 0;

    // Model: whether scanning, and linear pixel index within the frame.
    bit m_act = 0, m_ls = 0, m_fs = 0;
    int m_pos = 0;

    always #5 board_clk = ~board_clk;

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                     .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                     .H_POL(1'b0), .V_POL(1'b0), .CW(4)) dut (
        .board_clk(board_clk), .rst(rst), .my_clk(my_clk), .run(run),
        .hs(hs), .vs(vs), .de(de), .currentX(cx), .currentY(cy),
        .line_start(ls), .frame_start(fs), .busy(busy));

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                     .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                     .H_POL(1'b1), .V_POL(1'b1), .CW(4)) dut_pos (
        .board_clk(board_clk), .rst(rst), .my_clk(my_clk), .run(run),
        .hs(hs2), .vs(vs2), .de(de2), .currentX(cx2), .currentY(cy2),
        .line_start(ls2), .frame_start(fs2), .busy(busy2));

    assign act1 = {hs, vs, de, cx, cy, ls, fs, busy};
    assign act2 = {hs2, vs2, de2, cx2, cy2, ls2, fs2, busy2};

    // Expected outputs of the active-low instance.
    function automatic logic [13:0] exp_vec();
        int h, v;
        logic ehs, evs, ede;
        logic [3:0] ex, ey;
        h   = m_pos % HT;
        v   = m_pos / HT;
        ehs = !(m_act && h >= HA + HFP && h < HA + HFP + HSY);
        evs = !(m_act && v >= VA + VFP && v < VA + VFP + VSY);
        ede = m_act && h < HA && v < VA;
        ex  = (h >= HA) ? 4'(HA - 1) : 4'(h);
        ey  = (v >= VA) ? 4'(VA - 1) : 4'(v);
        return {ehs, evs, ede, ex, ey, m_ls, m_fs, m_act};
    endfunction

    task automatic model_reset();
        m_act = 0; m_pos = 0; m_ls = 0; m_fs = 0;
    endtask

    task automatic step(input bit mc, input bit r);
        my_clk = mc;
        run    = r;
        @(posedge board_clk);
        m_ls = 0;
        m_fs = 0;
        if (mc) begin
            if (!m_act) begin
                if (r) begin m_act = 1; m_pos = 0; m_ls = 1; m_fs = 1; end
            end else if (m_pos == NPIX - 1) begin
                m_pos = 0;
                if (r) begin m_ls = 1; m_fs = 1; end
                else m_act = 0;
            end else begin
                m_pos++;
                m_ls = (m_pos % HT == 0);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] e;
        rst = 1; run = 0; my_clk = 1;
        repeat (3) @(posedge board_clk);
        #1;
        model_reset();
        n_checks++;
        if (act1 !== 14'h3000) $display("FAIL reset_low got=%h expected=%h", act1, 14'h3000);
        else n_pass++;
        n_checks++;
        if (act2 !== 14'h0000) $display("FAIL reset_high got=%h expected=%h", act2, 14'h0000);
        else n_pass++;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0);
            e = exp_vec();
            n_checks++;
            if ({act1, act2} !== {e, e ^ POL_FLIP})
                $display("FAIL idle_hold i=%0d got=%h expected=%h", i, {act1, act2}, {e, e ^ POL_FLIP});
            else n_pass++;
        end
    endtask

    task automatic test_full_frame();
        logic [13:0] e;
        int last_fs = -1, last_ls = -1, de_cnt = 0;
        for (int c = 0; c < 2 * NPIX + 5; c++) begin
            step(1, 1);
            e = exp_vec();
            n_checks++;
            if ({act1, act2} !== {e, e ^ POL_FLIP})
                $display("FAIL frame c=%0d got=%h expected=%h", c, {act1, act2}, {e, e ^ POL_FLIP});
            else n_pass++;
            if (m_pos == 1 * HT + 12) begin
                n_checks++;
                if (cx !== 4'd7 || cy !== 4'd1) $display("FAIL clamp_x got=%0d,%0d expected=7,1", cx, cy);
                else n_pass++;
            end
            if (m_pos == 6 * HT) begin
                n_checks++;
                if (cy !== 4'd3) $display("FAIL clamp_y got=%0d expected=3", cy);
                else n_pass++;
            end
            if (fs === 1'b1) begin
                if (last_fs >= 0) begin
                    n_checks++;
                    if (c - last_fs != NPIX) $display("FAIL fs_period got=%0d expected=%0d", c - last_fs, NPIX);
                    else n_pass++;
                    n_checks++;
                    if (de_cnt != HA * VA) $display("FAIL de_count got=%0d expected=%0d", de_cnt, HA * VA);
                    else n_pass++;
                end
                last_fs = c;
                de_cnt  = 0;
            end
            if (de === 1'b1) de_cnt++;
            if (ls === 1'b1) begin
                if (last_ls >= 0) begin
                    n_checks++;
                    if (c - last_ls != HT) $display("FAIL ls_period got=%0d expected=%0d", c - last_ls, HT);
                    else n_pass++;
                end
                last_ls = c;
            end
        end
    endtask

    task automatic test_stop();
        logic [13:0] e;
        int k;
        bit seen_idle = 0;
        for (int i = 0; i < 2 * NPIX && m_pos != 2 * HT + 4; i++) step(1, 1);
        for (k = 1; k <= NPIX + 5; k++) begin
            step(1, 0);
            e = exp_vec();
            n_checks++;
            if ({act1, act2} !== {e, e ^ POL_FLIP})
                $display("FAIL drain k=%0d got=%h expected=%h", k, {act1, act2}, {e, e ^ POL_FLIP});
            else n_pass++;
            if (busy === 1'b0) begin seen_idle = 1; break; end
        end
        n_checks++;
        if (!seen_idle || k != NPIX - (2 * HT + 4))
            $display("FAIL stop_latency got=%0d expected=%0d", seen_idle ? k : -1, NPIX - (2 * HT + 4));
        else n_pass++;
        n_checks++;
        if (fs !== 1'b0 || ls !== 1'b0) $display("FAIL stop_strobe got=%b%b expected=00", fs, ls);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            e = exp_vec();
            n_checks++;
            if ({act1, act2} !== {e, e ^ POL_FLIP})
                $display("FAIL stay_idle got=%h expected=%h", {act1, act2}, {e, e ^ POL_FLIP});
            else n_pass++;
        end
    endtask

    task automatic test_rerun();
        logic [13:0] e;
        int gaps = 0;
        bit r;
        step(1, 1);
        for (int i = 0; i < NPIX; i++) begin
            r = (m_pos < 2 * HT + 4) || (m_pos >= 6 * HT + 4);
            step(1, r);
            e = exp_vec();
            n_checks++;
            if ({act1, act2} !== {e, e ^ POL_FLIP})
                $display("FAIL rerun i=%0d got=%h expected=%h", i, {act1, act2}, {e, e ^ POL_FLIP});
            else n_pass++;
            if (busy !== 1'b1) gaps++;
            if (m_pos == 0) break;
        end
        n_checks++;
        if (fs !== 1'b1 || busy !== 1'b1) $display("FAIL rerun_wrap got=%b%b expected=11", fs, busy);
        else n_pass++;
        n_checks++;
        if (gaps != 0) $display("FAIL rerun_gap got=%0d expected=0", gaps);
        else n_pass++;
    endtask

    task automatic test_slow_clk();
        logic [13:0] e;
        int last_fs = -1;
        bit pfs = 0, pls = 0;
        for (int c = 0; c < 4 * NPIX + 200; c++) begin
            step(c % 4 == 3, 1);
            e = exp_vec();
            n_checks++;
            if ({act1, act2} !== {e, e ^ POL_FLIP})
                $display("FAIL slow c=%0d got=%h expected=%h", c, {act1, act2}, {e, e ^ POL_FLIP});
            else n_pass++;
            if (pfs || pls) begin
                n_checks++;
                if (fs !== 1'b0 || ls !== 1'b0) $display("FAIL strobe_width got=%b%b expected=00", fs, ls);
                else n_pass++;
            end
            if (fs === 1'b1) begin
                if (last_fs >= 0) begin
                    n_checks++;
                    if (c - last_fs != 4 * NPIX)
                        $display("FAIL slow_period got=%0d expected=%0d", c - last_fs, 4 * NPIX);
                    else n_pass++;
                end
                last_fs = c;
            end
            pfs = (fs === 1'b1);
            pls = (ls === 1'b1);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 2 * NPIX && !(m_act && m_pos == 2 * HT + 5); i++) step(1, 1);
        #2 rst = 1;
        #1;
        n_checks++;
        if (act1 !== 14'h3000) $display("FAIL async_rst_low got=%h expected=%h", act1, 14'h3000);
        else n_pass++;
        n_checks++;
        if (act2 !== 14'h0000) $display("FAIL async_rst_high got=%h expected=%h", act2, 14'h0000);
        else n_pass++;
        @(posedge board_clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_random();
        logic [13:0] e;
        bit r = 1;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 149) == 0) r = !r;
            step($urandom_range(0, 2) != 0, r);
            e = exp_vec();
            n_checks++;
            if ({act1, act2} !== {e, e ^ POL_FLIP})
                $display("FAIL random c=%0d got=%h expected=%h", c, {act1, act2}, {e, e ^ POL_FLIP});
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stop();
        test_rerun();
        test_slow_clk();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
